jtag_wb_bridge: RTL and testbench
=================================

# jtag_wb_bridge

Converts the single-cycle management requests issued by the JTAG debug TAP into classic Wishbone master cycles on the core's system bus. It holds the result of the most recent read for the TAP to collect. It also reports bus errors, timeouts and dropped requests. It sits directly downstream of the TAP's management port and upstream of the core's Wishbone interconnect.

## Interface
- BASE_ADDRESS, 32'h0000_0000, ORed into every generated Wishbone byte address
- TIMEOUT_CYCLES, 255, maximum Wishbone cycles to wait for ack/err; legal range 2..255
- clk  input  1  system clock; the only clock
- rst  input  1  reset, asynchronous, active-high
- management_enable  input  1  one-cycle request strobe from the TAP
- management_writeEnable  input  1  1 = write, 0 = read; qualified by enable
- management_byteSelect  input  4  byte lanes; 4'h0 means all lanes
- management_address  input  20  word address
- management_writeData  input  32  write data
- management_readData  output  32  last completed read result
- management_busy  output  1  a Wishbone cycle is in progress
- management_error  output  1  sticky: last transaction ended in err or timeout
- management_overrun  output  1  sticky: a request arrived while busy and was dropped
- wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  classic Wishbone master controls
- wb_sel_o  output  4  byte selects
- wb_adr_o  output  32  byte address
- wb_dat_o  output  32  write data
- wb_dat_i  input  32  read data
- wb_ack_i, wb_err_i  input  1 each  slave termination

## Operation
- States: IDLE and BUS. management_busy = (state == BUS).
- IDLE + enable: latch the request and enter BUS. Latch wb_we_o = writeEnable.
  - wb_sel_o = byteSelect, or 4'hF when byteSelect is 4'h0.
  - wb_adr_o = BASE_ADDRESS | {10'b0, address, 2'b00}.
  - wb_dat_o = writeData on writes, 0 on reads.
  - Clear management_error and management_overrun, and zero the timeout counter.
- BUS: wb_cyc_o = wb_stb_o = 1. Address, select, data and we are held stable.
- BUS + wb_ack_i: on a read, management_readData <= wb_dat_i. Go to IDLE.
- BUS + wb_err_i: management_error <= 1. On a read, management_readData <= 32'hFFFF_FFFF. Go to IDLE.
- Simultaneous ack and err: err wins.
- Timeout: the counter increments each BUS cycle with no ack or err. At TIMEOUT_CYCLES-1 the block behaves exactly as for err.
- Ack or err in the same cycle the timeout fires: the slave response wins.
- BUS + enable: the request is dropped and management_overrun <= 1. This includes the cycle in which ack arrives. The current transaction is unaffected.
- Write completion never changes management_readData.
- Reset values: all Wishbone outputs 0, management_readData 0, busy/error/overrun 0, state IDLE, counter 0.
- Reset mid-cycle: wb_cyc_o and wb_stb_o drop immediately (asynchronously). No data is captured.

## Timing
- Request strobe at edge N: wb_cyc_o/wb_stb_o are high from N+1. All outputs are registered; there are no combinational paths from the management inputs.
- Ack sampled at edge M: cyc/stb are low and readData is valid from M+1. Busy falls at M+1.
- A new request is accepted from edge M+1 onward, so minimum request spacing is 2 cycles with a zero-wait slave.
- Zero-wait slave (ack in the first BUS cycle): readData is valid 2 cycles after the strobe.
- Timeout abort: cyc drops TIMEOUT_CYCLES cycles after entering BUS.

## Configuration
- JTAG_WB_TIMEOUT_EN defined: the timeout counter and abort described above are present.
- JTAG_WB_TIMEOUT_EN undefined: no counter. BUS waits indefinitely for ack/err. TIMEOUT_CYCLES is ignored. management_error is set only by wb_err_i.

## Structure
- Shared package jtag_wb_pkg holds:
  - state encodings (IDLE = 1'b0, BUS = 1'b1);
  - ERROR_READ_VALUE = 32'hFFFF_FFFF;
  - the full-lane select constant 4'hF.
- One sub-module, jtag_wb_timeout: 8-bit clear/increment counter with an expired flag. It is instantiated only under JTAG_WB_TIMEOUT_EN.

## Test plan
- Read, addr 20'h00010, sel 4'h0, slave acks in the first BUS cycle with 32'hDEADBEEF -> wb_adr_o 32'h00000040, wb_sel_o 4'hF, readData 32'hDEADBEEF two cycles after the strobe, error 0.
- Write, addr 20'hFFFFF, sel 4'h3, data 32'h12345678, BASE_ADDRESS 32'h3000_0000, ack after 3 wait cycles -> wb_adr_o 32'h303F_FFFC, wb_we_o 1, wb_dat_o 32'h12345678, cyc high 4 cycles, readData unchanged.
- Read with err and ack asserted together -> error 1, readData 32'hFFFF_FFFF. A following successful request clears error.
- Timeout enabled, TIMEOUT_CYCLES 8, silent slave -> cyc drops after 8 BUS cycles, error 1, readData 32'hFFFF_FFFF. With the macro undefined, cyc is still high at 1000 cycles.
- Second strobe one cycle after the first, plus a strobe in the ack cycle -> overrun 1, exactly one Wishbone cycle, first request's data returned.
- rst asserted mid-BUS -> cyc/stb low without a clock edge, all outputs at reset values, next request executes normally.

Source files
------------

// File: rtl/jtag_wb_pkg.sv
// rtl/jtag_wb_pkg.sv - shared types and constants for the JTAG-to-Wishbone bridge
//
// Holds the bridge state encoding, the value returned on a failed read,
// the all-lanes select constant and the byte-select expansion helper.
package jtag_wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    localparam logic [31:0] ERROR_READ_VALUE = 32'hFFFF_FFFF;
    localparam logic [3:0]  SEL_ALL_LANES    = 4'hF;

    // A TAP select of zero is shorthand for a full-word access.
    function automatic logic [3:0] expand_sel(input logic [3:0] sel);
        return (sel == 4'h0) ? SEL_ALL_LANES : sel;
    endfunction

endpackage

// File: rtl/jtag_wb_timeout.sv
// rtl/jtag_wb_timeout.sv - 8-bit clear/increment bus-cycle watchdog
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear_i    zero the counter (new transaction accepted)
//   inc_i      count one bus cycle that ended without a slave response
//   expired_o  counter has reached LIMIT-1; the current cycle is the last one
module jtag_wb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [7:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else if (clear_i) begin
            count_q <= 8'd0;
        end else if (inc_i) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Counter is zero in the first bus cycle, so matching LIMIT-1 aborts
    // exactly LIMIT cycles after cyc rises.
    assign expired_o = (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/jtag_wb_bridge.sv
// rtl/jtag_wb_bridge.sv - turns single-cycle TAP management strobes into classic Wishbone cycles
//
// Optional feature: define JTAG_WB_TIMEOUT_EN to abort unanswered bus cycles
// after TIMEOUT_CYCLES cycles; otherwise the bridge waits forever for ack/err.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   management_enable/writeEnable  request strobe and direction from the TAP
//   management_byteSelect/address  byte lanes (0 = all) and word address
//   management_writeData           write payload
//   management_readData            result of the last completed read
//   management_busy                a Wishbone cycle is in progress
//   management_error/overrun       sticky status, cleared by the next accepted request
//   wb_*                           classic Wishbone master port
module jtag_wb_bridge
    import jtag_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        management_enable,
    input  logic        management_writeEnable,
    input  logic [3:0]  management_byteSelect,
    input  logic [19:0] management_address,
    input  logic [31:0] management_writeData,
    output logic [31:0] management_readData,
    output logic        management_busy,
    output logic        management_error,
    output logic        management_overrun,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    state_e      state_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic        overrun_q;
    logic        timeout_w;
    logic        accept_w;

    assign accept_w = (state_q == IDLE) && management_enable;

`ifdef JTAG_WB_TIMEOUT_EN
    jtag_wb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept_w),
        .inc_i     ((state_q == BUS) && !wb_ack_i && !wb_err_i),
        .expired_o (timeout_w)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_w          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            rdata_q   <= 32'h0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        state_q   <= BUS;
                        we_q      <= management_writeEnable;
                        sel_q     <= expand_sel(management_byteSelect);
                        adr_q     <= BASE_ADDRESS | {10'b0, management_address, 2'b00};
                        dat_q     <= management_writeEnable ? management_writeData : 32'h0;
                        error_q   <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                end
                BUS: begin
                    // Any strobe while a cycle is open is dropped, including
                    // the strobe that coincides with the terminating ack.
                    if (management_enable) begin
                        overrun_q <= 1'b1;
                    end
                    // err beats ack; a real ack beats a simultaneous timeout.
                    if (wb_err_i || (timeout_w && !wb_ack_i)) begin
                        error_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= ERROR_READ_VALUE;
                        end
                        state_q <= IDLE;
                    end else if (wb_ack_i) begin
                        if (!we_q) begin
                            rdata_q <= wb_dat_i;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_cyc_o            = (state_q == BUS);
    assign wb_stb_o            = (state_q == BUS);
    assign wb_we_o             = we_q;
    assign wb_sel_o            = sel_q;
    assign wb_adr_o            = adr_q;
    assign wb_dat_o            = dat_q;
    assign management_busy     = (state_q == BUS);
    assign management_readData = rdata_q;
    assign management_error    = error_q;
    assign management_overrun  = overrun_q;

endmodule

// File: tb/tb_jtag_wb_bridge.sv
// tb/tb_jtag_wb_bridge.sv - self-checking bench for jtag_wb_bridge
module tb_jtag_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TO   = 8;

    logic        clk;
    logic        rst;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [19:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_busy;
    logic        m_err;
    logic        m_ovr;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: what the TAP should see after each transaction.
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_ovr;

    jtag_wb_bridge #(
        .BASE_ADDRESS   (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .management_enable      (m_en),
        .management_writeEnable (m_we),
        .management_byteSelect  (m_sel),
        .management_address     (m_addr),
        .management_writeData   (m_wdata),
        .management_readData    (m_rdata),
        .management_busy        (m_busy),
        .management_error       (m_err),
        .management_overrun     (m_ovr),
        .wb_cyc_o               (wb_cyc),
        .wb_stb_o               (wb_stb),
        .wb_we_o                (wb_we),
        .wb_sel_o               (wb_sel),
        .wb_adr_o               (wb_adr),
        .wb_dat_o               (wb_dat_o),
        .wb_dat_i               (wb_dat_i),
        .wb_ack_i               (wb_ack),
        .wb_err_i               (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".busy"},    {31'b0, m_busy}, 32'h0);
        check({tag, ".cyc"},     {31'b0, wb_cyc}, 32'h0);
        check({tag, ".rdata"},   m_rdata, exp_rd);
        check({tag, ".error"},   {31'b0, m_err}, {31'b0, exp_err});
        check({tag, ".overrun"}, {31'b0, m_ovr}, {31'b0, exp_ovr});
    endtask

    // One complete request: strobe, `waits` silent cycles, then the chosen
    // slave response. extra[0] strobes again in the first bus cycle,
    // extra[1] strobes in the response cycle.
    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [19:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                          input logic ack, input logic err, input logic [1:0] extra);
        logic [31:0] e_adr;
        logic [3:0]  e_sel;
        int          cyc_cnt;
        e_adr = BASE | (32'(addr) * 32'd4);
        e_sel = (sel == 4'h0) ? 4'hF : sel;
        m_en = 1'b1; m_we = we; m_sel = sel; m_addr = addr; m_wdata = wdata;
        tick;
        m_en = 1'b0;
        m_addr = 20'($urandom); m_wdata = $urandom; m_sel = 4'($urandom); m_we = ~we;
        check("txn.stb", {31'b0, wb_stb}, 32'h1);
        check("txn.busy", {31'b0, m_busy}, 32'h1);
        check("txn.adr", wb_adr, e_adr);
        check("txn.sel", {28'b0, wb_sel}, {28'b0, e_sel});
        check("txn.we", {31'b0, wb_we}, {31'b0, we});
        check("txn.dat", wb_dat_o, we ? wdata : 32'h0);
        check("txn.err_clr", {31'b0, m_err}, 32'h0);
        check("txn.ovr_clr", {31'b0, m_ovr}, 32'h0);
        cyc_cnt = 0;
        for (int i = 0; i <= waits; i++) begin
            if (wb_cyc) cyc_cnt++;
            if (i == 0 && extra[0]) m_en = 1'b1;
            if (i == waits) begin
                wb_ack = ack; wb_err = err; wb_dat_i = rdata;
                if (extra[1]) m_en = 1'b1;
            end else begin
                wb_dat_i = $urandom;
            end
            tick;
            m_en = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
            if (i < waits) check("txn.adr_hold", wb_adr, e_adr);
        end
        check("txn.cyc_len", cyc_cnt, waits + 1);
        if (err) begin
            exp_err = 1'b1;
            if (!we) exp_rd = 32'hFFFF_FFFF;
        end else begin
            exp_err = 1'b0;
            if (!we) exp_rd = rdata;
        end
        exp_ovr = |extra;
        check_status("txn.end");
    endtask

    initial begin
        int          n;
        logic [31:0] rd;
        rst = 1'b1; m_en = 1'b0; m_we = 1'b0; m_sel = 4'h0; m_addr = 20'h0; m_wdata = 32'h0;
        wb_dat_i = 32'h0; wb_ack = 1'b0; wb_err = 1'b0;
        exp_rd = 32'h0; exp_err = 1'b0; exp_ovr = 1'b0;
        tick; tick;
        check_status("reset");
        check("reset.stb", {31'b0, wb_stb}, 32'h0);
        check("reset.adr", wb_adr, 32'h0);
        check("reset.sel", {28'b0, wb_sel}, 32'h0);
        check("reset.dat", wb_dat_o, 32'h0);
        rst = 1'b0;
        tick;

        // Zero-wait read, full-lane shorthand.
        do_txn(1'b0, 4'h0, 20'h00010, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 2'b00);
        // Write at the top word address with 3 wait states; readData untouched.
        do_txn(1'b1, 4'h3, 20'hFFFFF, 32'h1234_5678, 32'hAAAA_5555, 3, 1'b1, 1'b0, 2'b00);
        // ack and err together: err wins.
        do_txn(1'b0, 4'h0, 20'h00123, 32'h0, 32'h0BAD_0BAD, 1, 1'b1, 1'b1, 2'b00);
        // Next good request clears the sticky error.
        do_txn(1'b0, 4'h5, 20'h00200, 32'h0, 32'h1111_2222, 2, 1'b1, 1'b0, 2'b00);
        // Strobe one cycle after the first and again in the ack cycle.
        do_txn(1'b0, 4'hF, 20'h00300, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 1'b0, 2'b11);
        // Strobe in the ack cycle of a zero-wait access.
        do_txn(1'b1, 4'h8, 20'h00301, 32'h5A5A_A5A5, 32'h0, 0, 1'b1, 1'b0, 2'b10);

        for (int t = 0; t < 24; t++) begin
            int          resp;
            logic [1:0]  ex;
            resp = $urandom_range(0, 3);
            ex   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            do_txn(1'($urandom), 4'($urandom), 20'($urandom), $urandom, $urandom,
                   $urandom_range(0, TO - 3), resp != 1, resp == 1 || resp == 3, ex);
        end

`ifdef JTAG_WB_TIMEOUT_EN
        // Silent slave on a read: abort after TO cycles, looks like err.
        m_en = 1'b1; m_we = 1'b0; m_sel = 4'h0; m_addr = 20'h00444;
        tick;
        m_en = 1'b0;
        n = 0;
        while (wb_cyc && n < 50) begin
            n++;
            tick;
        end
        check("timeout.len", n, TO);
        exp_err = 1'b1; exp_rd = 32'hFFFF_FFFF; exp_ovr = 1'b0;
        check_status("timeout.end");
        // ack in the very cycle the timeout would fire: the slave wins.
        do_txn(1'b0, 4'h0, 20'h00445, 32'h0, 32'h7777_0001, TO - 1, 1'b1, 1'b0, 2'b00);
`else
        // No watchdog: a silent slave holds the cycle open indefinitely.
        m_en = 1'b1; m_we = 1'b0; m_sel = 4'h0; m_addr = 20'h00444;
        tick;
        m_en = 1'b0;
        repeat (1000) tick;
        check("nowatchdog.cyc", {31'b0, wb_cyc}, 32'h1);
        check("nowatchdog.err", {31'b0, m_err}, 32'h0);
        rd = $urandom;
        wb_ack = 1'b1; wb_dat_i = rd;
        tick;
        wb_ack = 1'b0;
        exp_err = 1'b0; exp_rd = rd; exp_ovr = 1'b0;
        check_status("nowatchdog.end");
`endif

        // Reset in the middle of a bus cycle drops cyc/stb without an edge.
        m_en = 1'b1; m_we = 1'b1; m_sel = 4'h0; m_addr = 20'h00999; m_wdata = 32'hFEED_FACE;
        tick;
        m_en = 1'b1;
        tick;
        m_en = 1'b0;
        check("midrst.cyc_before", {31'b0, wb_cyc}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst.cyc", {31'b0, wb_cyc}, 32'h0);
        check("midrst.stb", {31'b0, wb_stb}, 32'h0);
        check("midrst.we", {31'b0, wb_we}, 32'h0);
        check("midrst.adr", wb_adr, 32'h0);
        check("midrst.dat", wb_dat_o, 32'h0);
        exp_rd = 32'h0; exp_err = 1'b0; exp_ovr = 1'b0;
        check_status("midrst");
        tick;
        rst = 1'b0;
        tick;
        do_txn(1'b0, 4'h0, 20'h00010, 32'h0, 32'h0000_ABCD, 1, 1'b1, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
